flash_read_arbiter: RTL and testbench

//  Shares the single QSPI flash read port between instruction fetch and the load unit (LSU loads from flash space).
//  One transaction in flight at a time, because the flash link is serial.
//  LSU has priority, with a starvation bound for fetch. A fetch redirect (branch/jump) cancels the pending fetch.

---
 rtl/flash_arb_pkg.sv | 25 ++
 rtl/flash_arb_priority.sv | 51 +++++
 rtl/flash_read_arbiter.sv | 163 ++++++++++++++++
 tb/tb_flash_read_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/flash_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : flash_arb_pkg
// Purpose  : Shared types for the flash read arbiter (FSM states, owner, widths)
// Revision : 1.0  initial release
// ============================================================================
package flash_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   typedef enum logic [1:0] {
      NONE  = 2'd0,
      FETCH = 2'd1,
      LSU   = 2'd2
   } arb_owner_t;

   localparam int STREAK_W = 4;

endpackage
`default_nettype wire

// File: rtl/flash_arb_priority.sv
`default_nettype none
// ============================================================================
// Module   : flash_arb_priority
// Purpose  : LSU-over-fetch winner selection with a bounded LSU streak
// Revision : 1.0  initial release
// ============================================================================
module flash_arb_priority
   import flash_arb_pkg::*;
#(
   parameter int MAX_LSU_STREAK = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic idle,
   input  logic fetch_req_valid,
   input  logic lsu_req_valid,
   input  logic fetch_flush,
   output logic grant_fetch,
   output logic grant_lsu
);

   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LSU_STREAK);

   logic [STREAK_W-1:0] streak_q;
   logic [STREAK_W-1:0] streak_d;
   logic                fetch_eligible;

   always_comb begin
      // A redirecting fetch is never granted in the cycle it flushes
      fetch_eligible = idle && fetch_req_valid && !fetch_flush;
      grant_lsu      = idle && lsu_req_valid && !(fetch_eligible && (streak_q == STREAK_MAX));
      grant_fetch    = fetch_eligible && !grant_lsu;

      streak_d = streak_q;
      if (grant_fetch || (idle && !fetch_req_valid)) begin
         streak_d = '0;
      end else if (grant_lsu && fetch_req_valid && (streak_q != STREAK_MAX)) begin
         streak_d = streak_q + STREAK_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         streak_q <= '0;
      end else begin
         streak_q <= streak_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/flash_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : flash_read_arbiter
// Purpose  : Shares the QSPI flash read port between fetch and LSU, one
//            transaction in flight. FLASH_ARB_PERF_EN adds grant/stall counters.
// Revision : 1.0  initial release
// ============================================================================
module flash_read_arbiter
   import flash_arb_pkg::*;
#(
   parameter int ADDR_WIDTH     = 24,
   parameter int DATA_WIDTH     = 64,
   parameter int MAX_LSU_STREAK = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fetch_req_valid,
   output logic                  fetch_req_ready,
   input  logic [ADDR_WIDTH-1:0] fetch_req_addr,
   input  logic                  fetch_flush,
   output logic                  fetch_resp_valid,
   output logic [DATA_WIDTH-1:0] fetch_resp_data,
   input  logic                  lsu_req_valid,
   output logic                  lsu_req_ready,
   input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
   output logic                  lsu_resp_valid,
   output logic [DATA_WIDTH-1:0] lsu_resp_data,
   output logic                  flash_req_valid,
   input  logic                  flash_req_ready,
   output logic [ADDR_WIDTH-1:0] flash_req_addr,
   input  logic                  flash_resp_valid,
   input  logic [DATA_WIDTH-1:0] flash_resp_data,
   output logic                  busy
`ifdef FLASH_ARB_PERF_EN
   ,
   output logic [31:0]           perf_fetch_grants,
   output logic [31:0]           perf_lsu_grants,
   output logic [31:0]           perf_fetch_stall
`endif
);

   arb_state_t            state_q, state_d;
   arb_owner_t            owner_q, owner_d;
   logic                  discard_q, discard_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  grant_fetch;
   logic                  grant_lsu;

   flash_arb_priority #(
      .MAX_LSU_STREAK (MAX_LSU_STREAK)
   ) u_prio (
      .clk             (clk),
      .rst             (rst),
      .idle            (state_q == IDLE),
      .fetch_req_valid (fetch_req_valid),
      .lsu_req_valid   (lsu_req_valid),
      .fetch_flush     (fetch_flush),
      .grant_fetch     (grant_fetch),
      .grant_lsu       (grant_lsu)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         owner_q   <= NONE;
         discard_q <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         discard_q <= discard_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      discard_d = discard_q;
      addr_d    = addr_q;
      data_d    = data_q;
      case (state_q)
         IDLE: begin
            if (grant_lsu) begin
               owner_d   = LSU;
               addr_d    = lsu_req_addr;
               discard_d = 1'b0;
               state_d   = ISSUE;
            end else if (grant_fetch) begin
               owner_d   = FETCH;
               addr_d    = fetch_req_addr;
               discard_d = 1'b0;
               state_d   = ISSUE;
            end
         end
         ISSUE: if (flash_req_ready) state_d = WAIT;
         WAIT: begin
            if (flash_resp_valid) begin
               data_d  = flash_resp_data;
               state_d = RESP;
            end
         end
         RESP: begin
            owner_d   = NONE;
            discard_d = 1'b0;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // The flash side still finishes a flushed fetch; only its response is dropped
      if ((state_q == ISSUE || state_q == WAIT) && owner_q == FETCH && fetch_flush) begin
         discard_d = 1'b1;
      end
   end

   always_comb begin
      fetch_req_ready  = grant_fetch;
      lsu_req_ready    = grant_lsu;
      flash_req_valid  = (state_q == ISSUE);
      flash_req_addr   = addr_q;
      fetch_resp_valid = (state_q == RESP) && (owner_q == FETCH) && !discard_q && !fetch_flush;
      lsu_resp_valid   = (state_q == RESP) && (owner_q == LSU);
      fetch_resp_data  = data_q;
      lsu_resp_data    = data_q;
      busy             = (state_q != IDLE);
   end

   a_resp_only_in_wait: assert property (@(posedge clk) disable iff (rst)
      flash_resp_valid |-> (state_q == WAIT));

`ifdef FLASH_ARB_PERF_EN
   logic [31:0] perf_fetch_grants_q, perf_fetch_grants_d;
   logic [31:0] perf_lsu_grants_q, perf_lsu_grants_d;
   logic [31:0] perf_fetch_stall_q, perf_fetch_stall_d;

   always_comb begin
      perf_fetch_grants_d = perf_fetch_grants_q + {31'd0, grant_fetch};
      perf_lsu_grants_d   = perf_lsu_grants_q + {31'd0, grant_lsu};
      perf_fetch_stall_d  = perf_fetch_stall_q + {31'd0, (fetch_req_valid && !fetch_req_ready)};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetch_grants_q <= '0;
         perf_lsu_grants_q   <= '0;
         perf_fetch_stall_q  <= '0;
      end else begin
         perf_fetch_grants_q <= perf_fetch_grants_d;
         perf_lsu_grants_q   <= perf_lsu_grants_d;
         perf_fetch_stall_q  <= perf_fetch_stall_d;
      end
   end

   assign perf_fetch_grants = perf_fetch_grants_q;
   assign perf_lsu_grants   = perf_lsu_grants_q;
   assign perf_fetch_stall  = perf_fetch_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_flash_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_flash_read_arbiter
// Purpose  : Directed + randomized bench for flash_read_arbiter against a
//            transaction-level model (FLASH_ARB_PERF_EN checks the counters).
// Revision : 1.0  initial release
// ============================================================================
module tb_flash_read_arbiter;

   localparam int MAXS = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_req_valid, fetch_req_ready, fetch_flush, fetch_resp_valid;
   logic [23:0] fetch_req_addr;
   logic [63:0] fetch_resp_data;
   logic        lsu_req_valid, lsu_req_ready, lsu_resp_valid;
   logic [23:0] lsu_req_addr;
   logic [63:0] lsu_resp_data;
   logic        flash_req_valid, flash_req_ready, flash_resp_valid, busy;
   logic [23:0] flash_req_addr;
   logic [63:0] flash_resp_data;
`ifdef FLASH_ARB_PERF_EN
   logic [31:0] perf_fetch_grants, perf_lsu_grants, perf_fetch_stall;
`endif

   always #5 clk = ~clk;

   flash_read_arbiter #(.ADDR_WIDTH(24), .DATA_WIDTH(64), .MAX_LSU_STREAK(MAXS)) dut (
      .clk(clk), .rst(rst),
      .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
      .fetch_req_addr(fetch_req_addr), .fetch_flush(fetch_flush),
      .fetch_resp_valid(fetch_resp_valid), .fetch_resp_data(fetch_resp_data),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
      .lsu_req_addr(lsu_req_addr), .lsu_resp_valid(lsu_resp_valid),
      .lsu_resp_data(lsu_resp_data),
      .flash_req_valid(flash_req_valid), .flash_req_ready(flash_req_ready),
      .flash_req_addr(flash_req_addr), .flash_resp_valid(flash_resp_valid),
      .flash_resp_data(flash_resp_data), .busy(busy)
`ifdef FLASH_ARB_PERF_EN
      , .perf_fetch_grants(perf_fetch_grants), .perf_lsu_grants(perf_lsu_grants),
      .perf_fetch_stall(perf_fetch_stall)
`endif
   );

   int npass = 0, ntotal = 0;

   // Requesters, flash responder and the transaction-level reference
   bit          f_pend, l_pend, flush_now, rnd;
   logic [23:0] f_addr, l_addr;
   int          txn;            // 0 none, 1 awaiting flash accept, 2 awaiting data, 3 response due
   bit          t_fetch, t_drop;
   logic [23:0] t_addr;
   int          streak, rdy_wait, lat_cnt, cfg_rdy, cfg_lat;
   int          n_fresp, n_lresp, pf, pl, ps;
   byte         glog[$];

   function automatic logic [63:0] data_of(input logic [23:0] a);
      if (a == 24'h000010) return 64'h11223344AADDEEFF;
      return {8'hC3, a, ~a, a[7:0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntotal = ntotal + 1;
      assert (obs === exp) npass = npass + 1;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic cycle();
      bit idle, felig, e_l, e_f, drop_now, e_fr, e_lr;
      @(negedge clk);
      fetch_req_valid  = f_pend;
      fetch_req_addr   = f_addr;
      lsu_req_valid    = l_pend;
      lsu_req_addr     = l_addr;
      fetch_flush      = flush_now;
      flash_req_ready  = (txn == 1 && rdy_wait == 0);
      flash_resp_valid = (txn == 2 && lat_cnt == 0);
      flash_resp_data  = flash_resp_valid ? data_of(t_addr) : {$urandom, $urandom};
      idle     = (txn == 0);
      felig    = idle && f_pend && !flush_now;
      e_l      = idle && l_pend && !(felig && streak == MAXS);
      e_f      = felig && !e_l;
      drop_now = t_drop || (flush_now && t_fetch);
      e_fr     = (txn == 3) && t_fetch && !drop_now;
      e_lr     = (txn == 3) && !t_fetch;
      #1;
      chk("fetch_ready", fetch_req_ready, e_f);
      chk("lsu_ready", lsu_req_ready, e_l);
      chk("flash_req_valid", flash_req_valid, txn == 1);
      chk("busy", busy, !idle);
      chk("fetch_resp_valid", fetch_resp_valid, e_fr);
      chk("lsu_resp_valid", lsu_resp_valid, e_lr);
      chk("streak", dut.u_prio.streak_q, streak);
      if (txn == 1) chk("flash_req_addr", flash_req_addr, t_addr);
      if (e_fr) chk("fetch_resp_data", fetch_resp_data, data_of(t_addr));
      if (e_lr) chk("lsu_resp_data", lsu_resp_data, data_of(t_addr));
      if (fetch_req_ready) glog.push_back(8'h46);
      if (lsu_req_ready) glog.push_back(8'h4C);
      if (fetch_resp_valid) n_fresp++;
      if (lsu_resp_valid) n_lresp++;
      if (e_f) pf++;
      if (e_l) pl++;
      if (f_pend && !e_f) ps++;
      if (e_f || (idle && !f_pend)) streak = 0;
      else if (e_l && f_pend && streak < MAXS) streak++;
      if (!idle && t_fetch && flush_now) t_drop = 1;
      case (txn)
         0: if (e_l || e_f) begin
               txn = 1; t_fetch = e_f; t_addr = e_f ? f_addr : l_addr; t_drop = 0;
               rdy_wait = rnd ? $urandom_range(0, 3) : cfg_rdy;
               if (e_f) f_pend = 0; else l_pend = 0;
            end
         1: if (rdy_wait == 0) begin
               txn = 2; lat_cnt = rnd ? $urandom_range(0, 6) : cfg_lat;
            end else rdy_wait--;
         2: if (lat_cnt == 0) txn = 3; else lat_cnt--;
         default: txn = 0;
      endcase
      flush_now = 0;
   endtask

   task automatic quiet_inputs();
      fetch_req_valid = 0; lsu_req_valid = 0; fetch_flush = 0;
      flash_req_ready = 0; flash_resp_valid = 0;
      fetch_req_addr = '0; lsu_req_addr = '0; flash_resp_data = '0;
   endtask

   function automatic logic [39:0] log_seq(input int n);
      logic [39:0] s = '0;
      for (int i = 0; i < n; i++) s = {s[31:0], (i < glog.size()) ? glog[i] : 8'h00};
      return s;
   endfunction

   initial begin
      int base;
      rst = 1; quiet_inputs();
      f_pend = 0; l_pend = 0; flush_now = 0; rnd = 0; txn = 0; streak = 0;
      t_fetch = 0; t_drop = 0; t_addr = '0; f_addr = '0; l_addr = '0;
      rdy_wait = 0; lat_cnt = 0; cfg_rdy = 0; cfg_lat = 0;
      n_fresp = 0; n_lresp = 0; pf = 0; pl = 0; ps = 0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_flash_req_valid", flash_req_valid, 0);
      chk("rst_flash_req_addr", flash_req_addr, 0);
      chk("rst_fetch_resp", {fetch_resp_valid, lsu_resp_valid}, 0);
      chk("rst_resp_data", fetch_resp_data | lsu_resp_data, 0);
      @(negedge clk); rst = 0;

      // Fetch-only, long flash latency
      cfg_rdy = 0; cfg_lat = 20; f_pend = 1; f_addr = 24'h000010;
      repeat (30) cycle();
      chk("t1_fetch_pulses", n_fresp, 1);
      chk("t1_lsu_pulses", n_lresp, 0);

      // Simultaneous requests: LSU first
      glog.delete(); cfg_lat = 3;
      f_pend = 1; f_addr = 24'h000020; l_pend = 1; l_addr = 24'h000018;
      repeat (20) cycle();
      chk("t2_order", log_seq(2), 40'h0000004C46);

      // Continuous LSU pressure: fetch wins after MAXS LSU grants
      glog.delete(); cfg_lat = 1;
      f_pend = 1; f_addr = 24'h000100;
      repeat (40) begin
         if (!l_pend) begin l_pend = 1; l_addr = 24'(($urandom_range(0, 255)) << 4); end
         cycle();
      end
      repeat (20) cycle();
      chk("t3_sequence", log_seq(5), 40'h4C4C4C4C46);

      // Flush while the fetch waits for data
      base = n_fresp; cfg_lat = 5;
      f_pend = 1; f_addr = 24'h000030;
      for (int i = 0; i < 20 && txn != 2; i++) cycle();
      chk("t4_in_wait", txn, 2);
      flush_now = 1; cycle();
      repeat (15) cycle();
      chk("t4_dropped", n_fresp - base, 0);
      f_pend = 1; f_addr = 24'h00000C;
      repeat (15) cycle();
      chk("t4_next_fetch", n_fresp - base, 1);

      // Reset in the middle of a flash request
      cfg_rdy = 3; f_pend = 1; f_addr = 24'h000050;
      for (int i = 0; i < 20 && txn != 1; i++) cycle();
      @(posedge clk); #2;
      chk("t5_issue", flash_req_valid, 1);
      quiet_inputs(); rst = 1; #1;
      chk("t5_rst_req_valid", flash_req_valid, 0);
      chk("t5_rst_busy", busy, 0);
      txn = 0; streak = 0; t_drop = 0; pf = 0; pl = 0; ps = 0;
      @(negedge clk); rst = 0;
      base = n_fresp; cfg_rdy = 0; f_pend = 1; f_addr = 24'h000060;
      repeat (12) cycle();
      chk("t5_after_rst", n_fresp - base, 1);

      // Random traffic with occasional redirects
      rnd = 1;
      repeat (1500) begin
         if (!f_pend && $urandom_range(0, 2) == 0) begin f_pend = 1; f_addr = 24'($urandom); end
         if (!l_pend && $urandom_range(0, 2) == 0) begin l_pend = 1; l_addr = 24'($urandom); end
         flush_now = ($urandom_range(0, 15) == 0);
         cycle();
      end
      repeat (60) cycle();
      chk("drained", txn, 0);
`ifdef FLASH_ARB_PERF_EN
      chk("perf_fetch_grants", perf_fetch_grants, pf);
      chk("perf_lsu_grants", perf_lsu_grants, pl);
      chk("perf_fetch_stall", perf_fetch_stall, ps);
`endif
      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
